// File: rtl/mem_stage_if.sv
// Bundles the EX/MEM inputs, the data-memory port and the MEM/WB outputs of the memory stage.
// Pure wiring, no latency.
// Backpressure travels upstream on mem_stall; the memory side completes with the one-cycle dmem_resp.
interface mem_stage_if;
  // EX/MEM candidate instruction
  logic        ex_valid;
  logic [6:0]  ex_opcode;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_alu_out;
  logic [31:0] ex_rs2_data;
  logic [4:0]  ex_rd;
  logic        ex_load_regfile;
  logic        flush;
  logic        mem_stall;

  // Data memory port
  logic        dmem_read;
  logic        dmem_write;
  logic [31:0] dmem_address;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_byte_enable;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;

  // MEM/WB register
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_load_regfile;
  logic        wb_misaligned;

  // The memory stage itself
  modport slave (
    input  ex_valid, ex_opcode, ex_funct3, ex_alu_out, ex_rs2_data, ex_rd, ex_load_regfile,
    input  flush, dmem_rdata, dmem_resp,
    output mem_stall, dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_byte_enable,
    output wb_valid, wb_rd, wb_data, wb_load_regfile, wb_misaligned
  );

  // The surrounding pipeline and data memory
  modport master (
    output ex_valid, ex_opcode, ex_funct3, ex_alu_out, ex_rs2_data, ex_rd, ex_load_regfile,
    output flush, dmem_rdata, dmem_resp,
    input  mem_stall, dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_byte_enable,
    input  wb_valid, wb_rd, wb_data, wb_load_regfile, wb_misaligned
  );
endinterface

// File: rtl/mem_stage.sv
// RV32I memory stage: issues loads/stores to data memory, aligns/extends load data, feeds MEM/WB.
// Latency: one edge for non-memory ops; loads/stores complete on the edge after the dmem_resp cycle.
// Backpressure: mem_stall holds EX/MEM while an aligned access waits for dmem_resp; flush kills it.
module mem_stage (
  input  logic       clk,
  input  logic       rst_n,
  mem_stage_if.slave bus
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  typedef struct packed {
    logic        valid;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [4:0]  rd;
    logic        load_regfile;
  } ex_reg_t;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        load_regfile;
    logic        misaligned;
  } wb_reg_t;

  ex_reg_t     r_q, r_d;
  wb_reg_t     wb_q, wb_d;
  logic [0:0]  state_q, state_d;

  logic        is_load, is_store, mem_op, misaligned, req;
  logic        mem_stall;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_data;

  // Decode the held instruction and decide whether it drives a memory request this cycle
  always_comb begin
    is_load    = (r_q.opcode == OP_LOAD);
    is_store   = (r_q.opcode == OP_STORE);
    mem_op     = is_load | is_store;
    misaligned = 1'b0;
    case (r_q.funct3[1:0])
      2'b01:   misaligned = mem_op & r_q.addr[0];
      2'b10,
      2'b11:   misaligned = mem_op & (|r_q.addr[1:0]);
      default: misaligned = 1'b0;
    endcase
    // flush removes the request in the same cycle so a killed access never reaches memory
    req       = r_q.valid & mem_op & ~misaligned & ~bus.flush;
    mem_stall = req & ~bus.dmem_resp;
  end

  // Store lane steering: byte enables follow the address, data is replicated to every lane
  always_comb begin
    be    = 4'b0000;
    wdata = r_q.sdata;
    case (r_q.funct3[1:0])
      2'b00: begin
        be    = 4'b0001 << r_q.addr[1:0];
        wdata = {4{r_q.sdata[7:0]}};
      end
      2'b01: begin
        be    = 4'b0011 << r_q.addr[1:0];
        wdata = {2{r_q.sdata[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = r_q.sdata;
      end
    endcase
  end

  // Load lane select and sign/zero extension
  always_comb begin
    case (r_q.addr[1:0])
      2'b00:   lane_byte = bus.dmem_rdata[7:0];
      2'b01:   lane_byte = bus.dmem_rdata[15:8];
      2'b10:   lane_byte = bus.dmem_rdata[23:16];
      default: lane_byte = bus.dmem_rdata[31:24];
    endcase
    lane_half = r_q.addr[1] ? bus.dmem_rdata[31:16] : bus.dmem_rdata[15:0];
    case (r_q.funct3)
      3'b000:  load_data = {{24{lane_byte[7]}}, lane_byte};
      3'b001:  load_data = {{16{lane_half[15]}}, lane_half};
      3'b100:  load_data = {24'h0, lane_byte};
      3'b101:  load_data = {16'h0, lane_half};
      default: load_data = bus.dmem_rdata;
    endcase
  end

  // Request tracking: WAIT while an issued access has not yet seen its response
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req && !bus.dmem_resp) state_d = WAIT;
      WAIT:    if (bus.dmem_resp || bus.flush) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // EX/MEM capture: frozen while stalled, a flushed candidate enters as a bubble
  always_comb begin
    r_d = r_q;
    if (!mem_stall) begin
      r_d.valid        = bus.ex_valid & ~bus.flush;
      r_d.opcode       = bus.ex_opcode;
      r_d.funct3       = bus.ex_funct3;
      r_d.addr         = bus.ex_alu_out;
      r_d.sdata        = bus.ex_rs2_data;
      r_d.rd           = bus.ex_rd;
      r_d.load_regfile = bus.ex_load_regfile;
    end
  end

  // MEM/WB next value: bubble while stalled or flushed, otherwise retire the held instruction
  always_comb begin
    wb_d = '0;
    if (!mem_stall && !bus.flush && r_q.valid) begin
      wb_d.valid = 1'b1;
      wb_d.rd    = r_q.rd;
      // Faulting address is reported for misaligned accesses, ALU result for everything else
      wb_d.data  = r_q.addr;
      if (misaligned) begin
        wb_d.misaligned = 1'b1;
      end else if (is_load) begin
        wb_d.data         = load_data;
        wb_d.load_regfile = r_q.load_regfile & (r_q.rd != 5'd0);
      end else if (!is_store) begin
        wb_d.load_regfile = r_q.load_regfile;
      end
    end
  end

  // State registers; reset abandons any outstanding access
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      r_q     <= '0;
      wb_q    <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      wb_q    <= wb_d;
    end
  end

  assign bus.mem_stall        = mem_stall;
  assign bus.dmem_read        = req & is_load;
  assign bus.dmem_write       = req & is_store;
  assign bus.dmem_address     = {r_q.addr[31:2], 2'b00};
  assign bus.dmem_wdata       = wdata;
  assign bus.dmem_byte_enable = (req & is_store) ? be : 4'b0000;

  assign bus.wb_valid         = wb_q.valid;
  assign bus.wb_rd            = wb_q.rd;
  assign bus.wb_data          = wb_q.data;
  assign bus.wb_load_regfile  = wb_q.load_regfile;
  assign bus.wb_misaligned    = wb_q.misaligned;

endmodule
